// File: rtl/femto_ctrl_pkg.sv
// femto_ctrl_pkg
// Shared definitions for the femtoRV32 multi-cycle controller: FSM state
// encoding, RV32I major opcodes, the opcode class produced by the decoder,
// and the datapath control encodings. The alu_op values are the ones
// ALUControlUnit decodes, so they must not be renumbered.
package femto_ctrl_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_TRAP   = 3'd7
  } state_e;

  // RV32I major opcodes (IR[6:0]).
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Instruction class, registered in DECODE.
  typedef enum logic [3:0] {
    CLS_R      = 4'd0,
    CLS_I_ALU  = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_AUIPC  = 4'd8,
    CLS_FENCE  = 4'd9,
    CLS_SYSTEM = 4'd10
  } op_class_e;

  // ALU operation class consumed by ALUControlUnit.
  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RTYPE  = 2'b10,
    ALU_ITYPE  = 2'b11
  } alu_op_e;

  // ALU operand A source.
  typedef enum logic [1:0] {
    SRC_A_RS1  = 2'b00,
    SRC_A_PC   = 2'b01,
    SRC_A_ZERO = 2'b10
  } alu_src_a_e;

  // ALU operand B source.
  localparam logic SRC_B_RS2 = 1'b0;
  localparam logic SRC_B_IMM = 1'b1;

  // Next-PC source.
  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_IMM   = 2'b01,
    PC_ALU   = 2'b10
  } pc_src_e;

  // Register-file write-back source.
  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  // Bundle of every control output, so the output decoder can clear all of
  // them with a single default assignment.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_write;
    alu_op_e    alu_op;
    alu_src_a_e alu_src_a;
    logic       alu_src_b;
    logic       reg_write;
    wb_sel_e    wb_sel;
    logic       pc_write;
    pc_src_e    pc_src;
    logic       instr_done;
    logic       halted;
    logic       illegal;
  } ctrl_t;

endpackage : femto_ctrl_pkg

// File: rtl/multicycle_control_fsm_decode.sv
// opcode_class_decode
// Purely combinational map from the 7-bit major opcode to an instruction
// class. valid_o is low for any opcode outside RV32I; class_o is then
// don't-care (driven as CLS_R).
//
// Ports:
//   opcode_i  in  7  IR[6:0]
//   class_o   out    decoded instruction class
//   valid_o   out 1  opcode is a recognised RV32I major opcode
module opcode_class_decode
  import femto_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output op_class_e  class_o,
  output logic       valid_o
);

  always_comb begin
    class_o = CLS_R;
    valid_o = 1'b1;
    unique case (opcode_i)
      OPC_R:      class_o = CLS_R;
      OPC_I_ALU:  class_o = CLS_I_ALU;
      OPC_LOAD:   class_o = CLS_LOAD;
      OPC_STORE:  class_o = CLS_STORE;
      OPC_BRANCH: class_o = CLS_BRANCH;
      OPC_JAL:    class_o = CLS_JAL;
      OPC_JALR:   class_o = CLS_JALR;
      OPC_LUI:    class_o = CLS_LUI;
      OPC_AUIPC:  class_o = CLS_AUIPC;
      OPC_FENCE:  class_o = CLS_FENCE;
      OPC_SYSTEM: class_o = CLS_SYSTEM;
      default:    valid_o = 1'b0;
    endcase
  end

endmodule : opcode_class_decode

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
// Multi-cycle main controller for the femtoRV32 core. Steps the datapath
// through FETCH / DECODE / EXEC / MEM / WB over a single memory port shared
// by instruction fetch and data access. Outputs are decoded from the state
// and the instruction class captured in DECODE; the only input-dependent
// outputs are the handshake completions (ir_write, STORE completion on
// mem_ready) and the branch target select (branch_cond).
//
// Optional feature: define CTRL_PERF_CNT_EN to add the cycle_cnt and
// instret_cnt performance counters (CNT_W bits, wrapping).
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   opcode      in 7  IR[6:0], stable from DECODE to end of instruction
//   branch_cond in 1  comparator result, used in EXEC of a branch
//   mem_ready   in 1  memory acknowledges the current request
//   mem_req/mem_we/mem_addr_sel   memory request, write strobe, address sel
//   ir_write                      latch fetched word into IR
//   alu_op/alu_src_a/alu_src_b    ALU class and operand selects
//   reg_write/wb_sel              register-file write enable and source
//   pc_write/pc_src               PC update enable and source
//   instr_done                    pulse in the last cycle of an instruction
//   halted/illegal                sticky terminal-state flags
//   cycle_cnt/instret_cnt         performance counters (CTRL_PERF_CNT_EN)
module multicycle_control_fsm
  import femto_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             branch_cond,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_write,
  output logic [1:0]       alu_op,
  output logic [1:0]       alu_src_a,
  output logic             alu_src_b,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             instr_done,
  output logic             halted,
  output logic             illegal
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  if (CNT_W < 1 || CNT_W > 64) begin : g_cnt_w_check
    $error("CNT_W must be in 1..64");
  end

  state_e    state_q, state_d;
  op_class_e cls_q, cls_d;
  op_class_e dec_cls;
  logic      dec_valid;
  ctrl_t     ctrl;

  opcode_class_decode u_decode (
    .opcode_i (opcode),
    .class_o  (dec_cls),
    .valid_o  (dec_valid)
  );

  // ---------------------------------------------------------------------
  // State and class registers
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      cls_q   <= CLS_R;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  // The class is captured once in DECODE and held for EXEC/MEM/WB, so the
  // later states do not depend on the opcode path timing.
  assign cls_d = (state_q == ST_DECODE) ? dec_cls : cls_q;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (!dec_valid) begin
          state_d = ST_TRAP;
        end else begin
          unique case (dec_cls)
            CLS_SYSTEM:                  state_d = ST_HALT;
            CLS_JAL, CLS_LUI, CLS_FENCE: state_d = ST_WB;
            default:                     state_d = ST_EXEC;
          endcase
        end
      end
      ST_EXEC: begin
        unique case (cls_q)
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_BRANCH:          state_d = ST_FETCH;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) state_d = (cls_q == CLS_STORE) ? ST_FETCH : ST_WB;
      end
      ST_WB:   state_d = ST_FETCH;
      // Terminal states: only reset leaves them.
      ST_HALT: state_d = ST_HALT;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_BOOT;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------
  always_comb begin
    ctrl = '0;
    unique case (state_q)
      ST_FETCH: begin
        ctrl.mem_req  = 1'b1;
        ctrl.ir_write = mem_ready;
      end

      ST_EXEC: begin
        unique case (cls_q)
          CLS_R: begin
            ctrl.alu_op = ALU_RTYPE;
          end
          CLS_I_ALU: begin
            ctrl.alu_op    = ALU_ITYPE;
            ctrl.alu_src_b = SRC_B_IMM;
          end
          CLS_LOAD, CLS_STORE, CLS_JALR: begin
            ctrl.alu_op    = ALU_ADD;
            ctrl.alu_src_b = SRC_B_IMM;
          end
          CLS_AUIPC: begin
            ctrl.alu_op    = ALU_ADD;
            ctrl.alu_src_a = SRC_A_PC;
            ctrl.alu_src_b = SRC_B_IMM;
          end
          CLS_BRANCH: begin
            // Branches retire here; the comparator result picks the target.
            ctrl.alu_op     = ALU_BRANCH;
            ctrl.pc_src     = branch_cond ? PC_IMM : PC_PLUS4;
            ctrl.pc_write   = 1'b1;
            ctrl.instr_done = 1'b1;
          end
          default: ;
        endcase
      end

      ST_MEM: begin
        // Address and write strobe depend only on state/class, so they stay
        // constant for as long as the request is waiting.
        ctrl.mem_req      = 1'b1;
        ctrl.mem_addr_sel = 1'b1;
        ctrl.mem_we       = (cls_q == CLS_STORE);
        if (cls_q == CLS_STORE && mem_ready) begin
          ctrl.pc_write   = 1'b1;
          ctrl.instr_done = 1'b1;
        end
      end

      ST_WB: begin
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
        unique case (cls_q)
          CLS_R, CLS_I_ALU, CLS_AUIPC: begin
            ctrl.reg_write = 1'b1;
            ctrl.wb_sel    = WB_ALU;
          end
          CLS_LOAD: begin
            ctrl.reg_write = 1'b1;
            ctrl.wb_sel    = WB_MEM;
          end
          CLS_JAL: begin
            ctrl.reg_write = 1'b1;
            ctrl.wb_sel    = WB_PC4;
            ctrl.pc_src    = PC_IMM;
          end
          CLS_JALR: begin
            ctrl.reg_write = 1'b1;
            ctrl.wb_sel    = WB_PC4;
            ctrl.pc_src    = PC_ALU;
          end
          CLS_LUI: begin
            ctrl.reg_write = 1'b1;
            ctrl.wb_sel    = WB_IMM;
          end
          default: ;  // FENCE: retire without writing a register
        endcase
      end

      // The terminal states are absorbing, so decoding the flags from the
      // state keeps them sticky until reset without extra flops.
      ST_HALT: ctrl.halted  = 1'b1;
      ST_TRAP: ctrl.illegal = 1'b1;
      default: ;
    endcase
  end

  assign mem_req      = ctrl.mem_req;
  assign mem_we       = ctrl.mem_we;
  assign mem_addr_sel = ctrl.mem_addr_sel;
  assign ir_write     = ctrl.ir_write;
  assign alu_op       = ctrl.alu_op;
  assign alu_src_a    = ctrl.alu_src_a;
  assign alu_src_b    = ctrl.alu_src_b;
  assign reg_write    = ctrl.reg_write;
  assign wb_sel       = ctrl.wb_sel;
  assign pc_write     = ctrl.pc_write;
  assign pc_src       = ctrl.pc_src;
  assign instr_done   = ctrl.instr_done;
  assign halted       = ctrl.halted;
  assign illegal      = ctrl.illegal;

`ifdef CTRL_PERF_CNT_EN
  // ---------------------------------------------------------------------
  // Performance counters (wrap modulo 2^CNT_W)
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q;
  logic             cycle_en;

  // BOOT and the terminal states are not part of program execution.
  assign cycle_en = !(state_q inside {ST_BOOT, ST_HALT, ST_TRAP});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      if (cycle_en)        cycle_cnt_q   <= cycle_cnt_q + CNT_W'(1);
      if (ctrl.instr_done) instret_cnt_q <= instret_cnt_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule : multicycle_control_fsm

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm. A table of per-cycle
// {opcode, mem_ready, branch_cond, expected outputs} records walks one
// instruction of every class back to back; hand-written sequences cover the
// trap, reset-during-request and (with CTRL_PERF_CNT_EN) counter cases.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_write;
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       halted;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic [6:0] op;
    logic       rdy;
    logic       bc;
    outs_t      exp;
    string      name;
  } vec_t;

  localparam logic [6:0] ADD   = 7'b0110011;
  localparam logic [6:0] ADDI  = 7'b0010011;
  localparam logic [6:0] LW    = 7'b0000011;
  localparam logic [6:0] SW    = 7'b0100011;
  localparam logic [6:0] BEQ   = 7'b1100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] FENCE = 7'b0001111;
  localparam logic [6:0] ECALL = 7'b1110011;
  localparam logic [6:0] BAD   = 7'b0000000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       branch_cond = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, mem_addr_sel, ir_write;
  logic [1:0] alu_op, alu_src_a, wb_sel, pc_src;
  logic       alu_src_b, reg_write, pc_write, instr_done, halted, illegal;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.CNT_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .branch_cond  (branch_cond),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_write     (ir_write),
    .alu_op       (alu_op),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .instr_done   (instr_done),
    .halted       (halted),
    .illegal      (illegal)
`ifdef CTRL_PERF_CNT_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
`endif
  );

  outs_t got;
  assign got = {mem_req, mem_we, mem_addr_sel, ir_write, alu_op, alu_src_a,
                alu_src_b, reg_write, wb_sel, pc_write, pc_src, instr_done,
                halted, illegal};

  // Expected-output builders; anything not set is 0.
  function automatic outs_t o_zero();
    return '0;
  endfunction

  function automatic outs_t o_fetch(input logic rdy);
    outs_t r = '0;
    r.mem_req  = 1'b1;
    r.ir_write = rdy;
    return r;
  endfunction

  function automatic outs_t o_exec(input logic [1:0] alu, input logic [1:0] sa,
                                   input logic sb);
    outs_t r = '0;
    r.alu_op    = alu;
    r.alu_src_a = sa;
    r.alu_src_b = sb;
    return r;
  endfunction

  function automatic outs_t o_mem(input logic we, input logic done);
    outs_t r = '0;
    r.mem_req      = 1'b1;
    r.mem_addr_sel = 1'b1;
    r.mem_we       = we;
    r.pc_write     = done;
    r.instr_done   = done;
    return r;
  endfunction

  function automatic outs_t o_wb(input logic rw, input logic [1:0] ws,
                                 input logic [1:0] ps);
    outs_t r = '0;
    r.reg_write  = rw;
    r.wb_sel     = ws;
    r.pc_src     = ps;
    r.pc_write   = 1'b1;
    r.instr_done = 1'b1;
    return r;
  endfunction

  function automatic outs_t o_branch(input logic taken);
    outs_t r = '0;
    r.alu_op     = 2'b01;
    r.pc_src     = taken ? 2'b01 : 2'b00;
    r.pc_write   = 1'b1;
    r.instr_done = 1'b1;
    return r;
  endfunction

  function automatic outs_t o_halt();
    outs_t r = '0;
    r.halted = 1'b1;
    return r;
  endfunction

  function automatic outs_t o_trap();
    outs_t r = '0;
    r.illegal = 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input outs_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and compare mid-cycle.
  task automatic step(input logic [6:0] op, input logic rdy, input logic bc,
                      input outs_t exp, input string name);
    @(negedge clk);
    opcode      = op;
    mem_ready   = rdy;
    branch_cond = bc;
    #1;
    check(name, exp);
  endtask

  // Reset pulse, then check the BOOT cycle (mem_ready high must be ignored).
  task automatic reset_seq();
    @(negedge clk);
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("in_reset", o_zero());
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("boot", o_zero());
  endtask

  vec_t tbl[$];

  function automatic void add(input logic [6:0] op, input logic rdy,
                              input logic bc, input outs_t exp, input string name);
    vec_t v;
    v.op = op; v.rdy = rdy; v.bc = bc; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endfunction

  initial begin
    // ADD, zero-wait: FETCH, DECODE, EXEC, WB.
    add(ADD,   1, 0, o_fetch(1),               "add_fetch");
    add(ADD,   1, 0, o_zero(),                 "add_decode");
    add(ADD,   1, 0, o_exec(2'b10, 2'b00, 0),  "add_exec");
    add(ADD,   1, 0, o_wb(1, 2'b00, 2'b00),    "add_wb");
    // ADDI.
    add(ADDI,  1, 0, o_fetch(1),               "addi_fetch");
    add(ADDI,  1, 0, o_zero(),                 "addi_decode");
    add(ADDI,  1, 0, o_exec(2'b11, 2'b00, 1),  "addi_exec");
    add(ADDI,  1, 0, o_wb(1, 2'b00, 2'b00),    "addi_wb");
    // LW with two wait cycles in MEM: 7 cycles FETCH..WB.
    add(LW,    1, 0, o_fetch(1),               "lw_fetch");
    add(LW,    1, 0, o_zero(),                 "lw_decode");
    add(LW,    1, 0, o_exec(2'b00, 2'b00, 1),  "lw_exec");
    add(LW,    0, 0, o_mem(0, 0),              "lw_mem_wait1");
    add(LW,    0, 0, o_mem(0, 0),              "lw_mem_wait2");
    add(LW,    1, 0, o_mem(0, 0),              "lw_mem_ack");
    add(LW,    1, 0, o_wb(1, 2'b01, 2'b00),    "lw_wb");
    // SW with one fetch wait; completes in MEM.
    add(SW,    0, 0, o_fetch(0),               "sw_fetch_wait");
    add(SW,    1, 0, o_fetch(1),               "sw_fetch_ack");
    add(SW,    1, 0, o_zero(),                 "sw_decode");
    add(SW,    1, 0, o_exec(2'b00, 2'b00, 1),  "sw_exec");
    add(SW,    1, 0, o_mem(1, 1),              "sw_mem_done");
    // BEQ taken, then not taken; completes in EXEC.
    add(BEQ,   1, 1, o_fetch(1),               "beq1_fetch");
    add(BEQ,   1, 1, o_zero(),                 "beq1_decode");
    add(BEQ,   1, 1, o_branch(1),              "beq_taken_exec");
    add(BEQ,   1, 0, o_fetch(1),               "beq0_fetch");
    add(BEQ,   1, 0, o_zero(),                 "beq0_decode");
    add(BEQ,   1, 0, o_branch(0),              "beq_not_taken_exec");
    // JAL: straight to WB.
    add(JAL,   1, 0, o_fetch(1),               "jal_fetch");
    add(JAL,   1, 0, o_zero(),                 "jal_decode");
    add(JAL,   1, 0, o_wb(1, 2'b10, 2'b01),    "jal_wb");
    // JALR.
    add(JALR,  1, 0, o_fetch(1),               "jalr_fetch");
    add(JALR,  1, 0, o_zero(),                 "jalr_decode");
    add(JALR,  1, 0, o_exec(2'b00, 2'b00, 1),  "jalr_exec");
    add(JALR,  1, 0, o_wb(1, 2'b10, 2'b10),    "jalr_wb");
    // LUI.
    add(LUI,   1, 0, o_fetch(1),               "lui_fetch");
    add(LUI,   1, 0, o_zero(),                 "lui_decode");
    add(LUI,   1, 0, o_wb(1, 2'b11, 2'b00),    "lui_wb");
    // AUIPC.
    add(AUIPC, 1, 0, o_fetch(1),               "auipc_fetch");
    add(AUIPC, 1, 0, o_zero(),                 "auipc_decode");
    add(AUIPC, 1, 0, o_exec(2'b00, 2'b01, 1),  "auipc_exec");
    add(AUIPC, 1, 0, o_wb(1, 2'b00, 2'b00),    "auipc_wb");
    // FENCE: retires in WB without a register write.
    add(FENCE, 1, 0, o_fetch(1),               "fence_fetch");
    add(FENCE, 1, 0, o_zero(),                 "fence_decode");
    add(FENCE, 1, 0, o_wb(0, 2'b00, 2'b00),    "fence_wb");
    // ECALL: HALT is absorbing, no memory traffic.
    add(ECALL, 1, 0, o_fetch(1),               "sys_fetch");
    add(ECALL, 1, 0, o_zero(),                 "sys_decode");
    add(ECALL, 1, 0, o_halt(),                 "halt1");
    add(ADD,   1, 1, o_halt(),                 "halt2");

    reset_seq();
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].op, tbl[i].rdy, tbl[i].bc, tbl[i].exp, tbl[i].name);

    // Halt clears on reset.
    reset_seq();

    // Unknown opcode: TRAP right after DECODE, no further requests.
    step(BAD, 1, 0, o_fetch(1), "bad_fetch");
    step(BAD, 1, 0, o_zero(),   "bad_decode");
    step(BAD, 1, 0, o_trap(),   "trap1");
    step(ADD, 1, 0, o_trap(),   "trap2");
    step(ADD, 0, 0, o_trap(),   "trap3");
    reset_seq();  // illegal must read 0 in reset and BOOT

    // Reset while FETCH waits: mem_req drops without a clock edge.
    step(ADD, 0, 0, o_fetch(0), "fetch_wait");
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", o_zero());
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("boot_after_mid_rst", o_zero());
    step(ADD, 0, 0, o_fetch(0), "fetch_after_mid_rst");

`ifdef CTRL_PERF_CNT_EN
    // Ten zero-wait R-type instructions: 4 counted cycles each.
    reset_seq();
    check_val("cycle_cnt_reset", cycle_cnt, 32'd0);
    check_val("instret_cnt_reset", instret_cnt, 32'd0);
    for (int k = 0; k < 10; k++) begin
      step(ADD, 1, 0, o_fetch(1),              "perf_fetch");
      step(ADD, 1, 0, o_zero(),                "perf_decode");
      step(ADD, 1, 0, o_exec(2'b10, 2'b00, 0), "perf_exec");
      step(ADD, 1, 0, o_wb(1, 2'b00, 2'b00),   "perf_wb");
    end
    @(negedge clk);
    #1;
    check_val("cycle_cnt_10_add", cycle_cnt, 32'd40);
    check_val("instret_cnt_10_add", instret_cnt, 32'd10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_multicycle_control_fsm
